// File: rtl/usb_rx_decode.sv
// USB receive front end: NRZI decode, SYNC search, bit-unstuffing and EOP detection.
// Optional build macro USB_RX_STUFF_ERR_EN enables the stuff_err pulse.
module usb_rx_decode (
    input  logic clk,
    input  logic rst_L,
    input  logic dp,
    input  logic dm,
    input  logic en_sync_L,
    output logic rx_bit,
    output logic bit_valid,
    output logic pause,
    output logic valid_sync,
    output logic eop,
    output logic stuff_err
);

    typedef enum logic {IDLE, RX} state_t;

    state_t     state_q, state_d;
    logic       prev_q, prev_d;        // 1 = last J/K line state was J
    logic [7:0] hist_q, hist_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] se0_q, se0_d;
    logic       rx_bit_d, bit_valid_d, pause_d, valid_sync_d, eop_d, stuff_hit_d;
    logic       is_jk, is_se0, line_j, dec;
    logic [7:0] hist_sh;

    assign is_jk   = dp ^ dm;
    assign is_se0  = ~dp & ~dm;
    assign line_j  = dp;
    assign dec     = (line_j == prev_q);
    assign hist_sh = {hist_q[6:0], dec};

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        hist_d       = hist_q;
        ones_d       = ones_q;
        se0_d        = is_se0 ? ((se0_q == 2'd3) ? 2'd3 : se0_q + 2'd1) : 2'd0;
        rx_bit_d     = 1'b0;
        bit_valid_d  = 1'b0;
        pause_d      = 1'b0;
        valid_sync_d = 1'b0;
        eop_d        = 1'b0;
        stuff_hit_d  = 1'b0;

        if (!is_jk) begin
            hist_d = 8'hFF;
        end else if (state_q == RX && line_j && se0_q >= 2'd2) begin
            // J closing an EOP is not a data bit; line returns to idle J
            eop_d   = 1'b1;
            prev_d  = 1'b1;
            ones_d  = 3'd0;
            state_d = IDLE;
        end else begin
            prev_d = line_j;
            hist_d = hist_sh;
            if (state_q == IDLE) begin
                if (!en_sync_L && hist_sh == 8'b0000_0001) begin
                    valid_sync_d = 1'b1;
                    ones_d       = 3'd1;
                    state_d      = RX;
                end
            end else begin
                bit_valid_d = 1'b1;
                rx_bit_d    = dec;
                if (ones_q == 3'd6) begin
                    pause_d     = 1'b1;
                    stuff_hit_d = dec;
                    ones_d      = 3'd0;
                end else begin
                    ones_d = dec ? ones_q + 3'd1 : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= IDLE;
            prev_q     <= 1'b1;
            hist_q     <= 8'hFF;
            ones_q     <= 3'd0;
            se0_q      <= 2'd0;
            rx_bit     <= 1'b0;
            bit_valid  <= 1'b0;
            pause      <= 1'b0;
            valid_sync <= 1'b0;
            eop        <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            hist_q     <= hist_d;
            ones_q     <= ones_d;
            se0_q      <= se0_d;
            rx_bit     <= rx_bit_d;
            bit_valid  <= bit_valid_d;
            pause      <= pause_d;
            valid_sync <= valid_sync_d;
            eop        <= eop_d;
        end
    end

`ifdef USB_RX_STUFF_ERR_EN
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) stuff_err <= 1'b0;
        else        stuff_err <= stuff_hit_d;
    end
`else
    logic unused_stuff;
    assign unused_stuff = stuff_hit_d;
    assign stuff_err    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_decode.sv
// Directed bench for usb_rx_decode: table of line states with expected registered outputs.
module tb_usb_rx_decode;

    logic clk = 1'b0;
    logic rst_L, dp, dm, en_sync_L;
    logic rx_bit, bit_valid, pause, valid_sync, eop, stuff_err;

    usb_rx_decode dut (
        .clk(clk), .rst_L(rst_L), .dp(dp), .dm(dm), .en_sync_L(en_sync_L),
        .rx_bit(rx_bit), .bit_valid(bit_valid), .pause(pause),
        .valid_sync(valid_sync), .eop(eop), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;

`ifdef USB_RX_STUFF_ERR_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif

    localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00, S1 = 2'b11;
    // expected output packing: {rx_bit, bit_valid, pause, valid_sync, eop, stuff_err}
    localparam logic [5:0] O_NONE = 6'b000000, O_ONE = 6'b110000, O_ZERO = 6'b010000,
                           O_SYNC = 6'b000100, O_EOP = 6'b000010;

    typedef struct {
        logic [1:0] ln;
        logic       en_L;
        logic [5:0] exp;
        string      nm;
    } vec_t;

    vec_t vq[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [5:0] outs();
        return {rx_bit, bit_valid, pause, valid_sync, eop, stuff_err};
    endfunction

    task automatic check(input logic [5:0] exp, input string nm);
        tests++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (rx_bit,bit_valid,pause,valid_sync,eop,stuff_err)",
                     nm, outs(), exp);
        end
    endtask

    // drive one bit time, then sample the registered result just after the edge
    task automatic step(input logic [1:0] ln, input logic en_L, input logic [5:0] exp, input string nm);
        {dp, dm}  = ln;
        en_sync_L = en_L;
        @(posedge clk);
        #1;
        check(exp, nm);
        @(negedge clk);
    endtask

    function automatic void add(input logic [1:0] ln, input logic en_L, input logic [5:0] exp, input string nm);
        vec_t v;
        v.ln = ln; v.en_L = en_L; v.exp = exp; v.nm = nm;
        vq.push_back(v);
    endfunction

    function automatic void add_sync(input logic en_L, input string nm);
        logic [1:0] pat [8];
        pat = '{K, J, K, J, K, J, K, K};
        for (int i = 0; i < 8; i++)
            add(pat[i], en_L, (i == 7 && !en_L) ? O_SYNC : O_NONE, nm);
    endfunction

    initial begin
        rst_L = 1'b0; dp = 1'b1; dm = 1'b0; en_sync_L = 1'b0;

        // reset with random line states
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {dp, dm} = 2'($urandom_range(0, 3));
            en_sync_L = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check(O_NONE, "reset_hold");
        end
        @(negedge clk);
        rst_L = 1'b1;

        add(J, 0, O_NONE, "idle_j");
        add(J, 0, O_NONE, "idle_j");
        add_sync(0, "sync");
        // five decoded ones then a transition in the stuffed slot
        for (int i = 0; i < 5; i++) add(K, 0, O_ONE, "ones_before_stuff");
        add(J, 0, 6'b011000, "stuff_ok");
        add(J, 0, O_ONE, "after_stuff");
        add(K, 0, O_ZERO, "zero_bit");
        // six ones after a zero, then a 1 in the stuffed slot
        for (int i = 0; i < 6; i++) add(K, 0, O_ONE, "ones_run");
        add(K, 0, {5'b11100, SE}, "stuff_err");
        add(S1, 0, O_NONE, "se1_in_rx");
        add(S0, 0, O_NONE, "eop_se0a");
        add(S0, 0, O_NONE, "eop_se0b");
        add(J, 0, O_EOP, "eop_j");
        add(J, 0, O_NONE, "idle_after_eop");
        add_sync(1, "sync_disabled");
        add(J, 0, O_NONE, "idle_pre");
        add(J, 0, O_NONE, "idle_pre");
        add_sync(0, "sync2");
        add(S0, 0, O_NONE, "single_se0");
        add(K, 0, O_ONE, "k_after_se0");
        add(J, 0, O_ZERO, "j_transition");
        add(S0, 0, O_NONE, "single_se0_j");
        add(J, 0, O_ONE, "j_after_se0");
        add_sync(0, "sync_in_rx");
        add(S0, 0, O_NONE, "eop3_se0");
        add(S0, 0, O_NONE, "eop3_se0");
        add(S0, 0, O_NONE, "eop3_se0");
        add(J, 0, O_EOP, "eop3_j");
        add(K, 0, O_NONE, "idle_k_after_eop");

        foreach (vq[i]) begin
            // SYNC seen while receiving is data: KJKJKJK = 0s, final K = 1
            if (vq[i].nm == "sync_in_rx")
                step(vq[i].ln, vq[i].en_L, (vq[i].ln == K && vq[i-1].ln == K) ? O_ONE : O_ZERO, vq[i].nm);
            else
                step(vq[i].ln, vq[i].en_L, vq[i].exp, vq[i].nm);
        end

        // mid-packet reset
        step(J, 0, O_NONE, "mr_idle");
        step(J, 0, O_NONE, "mr_idle");
        begin
            logic [1:0] pat [8];
            pat = '{K, J, K, J, K, J, K, K};
            for (int i = 0; i < 8; i++) step(pat[i], 0, (i == 7) ? O_SYNC : O_NONE, "mr_sync");
        end
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? J : K, 0, O_ZERO, "mr_data");
        {dp, dm} = J;
        @(posedge clk); #3;
        rst_L = 1'b0;
        #1;
        check(O_NONE, "mr_async_clear");
        @(negedge clk); @(negedge clk);
        rst_L = 1'b1;
        begin
            logic [1:0] pat [8];
            pat = '{J, J, K, J, K, J, K, J};
            for (int i = 0; i < 8; i++) step(pat[i], 0, O_NONE, "mr_no_sync_data");
        end
        step(J, 0, O_NONE, "mr_idle2");
        begin
            logic [1:0] pat [8];
            pat = '{K, J, K, J, K, J, K, K};
            for (int i = 0; i < 8; i++) step(pat[i], 0, (i == 7) ? O_SYNC : O_NONE, "mr_resync");
        end
        step(J, 0, O_ZERO, "mr_first_bit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
